// File: rtl/multifunction_shifter_16.sv
// 16-bit bidirectional barrel rotator with a registered result.
// Left rotates reuse the right-rotate log shifter by reversing bit order on both sides.
module multifunction_shifter_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [3:0]  amt,
  input  logic        lr,
  output logic [15:0] y
);

  localparam int unsigned W = 16;

  logic [W-1:0] rin_c;
  logic [W-1:0] s0_c;
  logic [W-1:0] s1_c;
  logic [W-1:0] s2_c;
  logic [W-1:0] s3_c;
  logic [W-1:0] r_c;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < int'(W); i++) begin
      o[i] = v[W-1-i];
    end
    return o;
  endfunction

  // Four right-rotate stages by 1, 2, 4 and 8 positions, each enabled by one amt bit.
  always_comb begin
    rin_c = lr ? bitrev(a) : a;
    s0_c  = amt[0] ? {rin_c[0],   rin_c[W-1:1]} : rin_c;
    s1_c  = amt[1] ? {s0_c[1:0],  s0_c[W-1:2]}  : s0_c;
    s2_c  = amt[2] ? {s1_c[3:0],  s1_c[W-1:4]}  : s1_c;
    s3_c  = amt[3] ? {s2_c[7:0],  s2_c[W-1:8]}  : s2_c;
    r_c   = lr ? bitrev(s3_c) : s3_c;
  end

  // Result register; reset wins over the data load.
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= r_c;
    end
  end

endmodule

// File: tb/tb_multifunction_shifter_16.sv
// Directed and randomized self-checking bench for multifunction_shifter_16.
// Inputs are driven on the falling edge; y is sampled 1 time unit after the rising edge.
module tb_multifunction_shifter_16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [3:0]  amt;
  logic        lr;
  logic [15:0] y;

  int unsigned n_tests;
  int unsigned n_fail;

  multifunction_shifter_16 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .amt (amt),
    .lr  (lr),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference rotate built from the plain shift expressions in a 32-bit context.
  function automatic logic [15:0] ref_rot(input logic [15:0] v, input logic [3:0] n,
                                          input logic left);
    logic [31:0] w;
    logic [31:0] r;
    w = {16'h0000, v};
    if (left) r = (w << n) | (w >> (16 - 32'(n)));
    else      r = (w >> n) | (w << (16 - 32'(n)));
    return r[15:0];
  endfunction

  task automatic apply(input logic r, input logic [15:0] av, input logic [3:0] am,
                       input logic d);
    @(negedge clk);
    rst = r;
    a   = av;
    amt = am;
    lr  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] av;
    logic [15:0] mid;
    logic [15:0] vec_a   [6];
    logic [3:0]  vec_amt [6];
    logic        vec_lr  [6];
    logic [15:0] vec_y   [6];

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a   = 16'hFFFF;
    amt = 4'd5;
    lr  = 1'b1;

    // Reset held for two edges
    apply(1'b1, 16'hFFFF, 4'd5, 1'b1);
    check("reset_edge1", y, 16'h0000);
    apply(1'b1, 16'h1234, 4'd3, 1'b0);
    check("reset_edge2", y, 16'h0000);

    // First edge after reset loads the inputs
    apply(1'b0, 16'hB3CD, 4'd1, 1'b0);
    check("post_reset_rotr1", y, 16'hD9E6);

    // Directed vectors, applied back-to-back with new inputs every cycle
    vec_a[0] = 16'hB3CD; vec_amt[0] = 4'd4;  vec_lr[0] = 1'b0; vec_y[0] = 16'hDB3C;
    vec_a[1] = 16'hB3CD; vec_amt[1] = 4'd1;  vec_lr[1] = 1'b1; vec_y[1] = 16'h679B;
    vec_a[2] = 16'hE3AA; vec_amt[2] = 4'd7;  vec_lr[2] = 1'b1; vec_y[2] = 16'hD571;
    vec_a[3] = 16'h0F0F; vec_amt[3] = 4'd0;  vec_lr[3] = 1'b0; vec_y[3] = 16'h0F0F;
    vec_a[4] = 16'hF0F0; vec_amt[4] = 4'd0;  vec_lr[4] = 1'b1; vec_y[4] = 16'hF0F0;
    vec_a[5] = 16'h8001; vec_amt[5] = 4'd15; vec_lr[5] = 1'b1; vec_y[5] = 16'hC000;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, vec_a[i], vec_amt[i], vec_lr[i]);
      check($sformatf("directed_%0d", i), y, vec_y[i]);
    end
    apply(1'b0, 16'h8001, 4'd15, 1'b0);
    check("max_amt_rotr15", y, 16'h0003);

    // Input changes between edges must not reach y
    #2;
    a   = 16'h5555;
    amt = 4'd3;
    lr  = 1'b1;
    #1;
    check("hold_between_edges", y, 16'h0003);

    // Reset mid-stream, then first deasserted edge loads immediately
    apply(1'b1, 16'hE3AA, 4'd7, 1'b1);
    check("reset_midstream", y, 16'h0000);
    apply(1'b0, 16'hE3AA, 4'd7, 1'b1);
    check("reset_release_load", y, 16'hD571);

    // Exhaustive amt/direction sweep over random operands
    for (int k = 0; k < 1000; k++) begin
      av = 16'($urandom);
      for (int n = 0; n < 16; n++) begin
        for (int d = 0; d < 2; d++) begin
          apply(1'b0, av, 4'(n), 1'(d));
          check($sformatf("sweep a=%h amt=%0d lr=%0d", av, n, d), y,
                ref_rot(av, 4'(n), 1'(d)));
        end
      end
    end

    // Left by n then right by n restores the operand
    for (int k = 0; k < 100; k++) begin
      av = 16'($urandom);
      for (int n = 0; n < 16; n++) begin
        apply(1'b0, av, 4'(n), 1'b1);
        mid = y;
        apply(1'b0, mid, 4'(n), 1'b0);
        check($sformatf("roundtrip a=%h amt=%0d", av, n), y, av);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
